// File: rtl/vcb_mod_cled_pkg.sv
// rtl/vcb_mod_cled_pkg.sv - shared helpers for the modulo up/down counter family
// Purpose : bound helper and parameter legality check used by vcb_mod_cled and vcb_mod_next.
// Contents: vcb_max(mod)                          -> largest held value (mod-1)
//           vcb_params_ok(width, mod, rst_val)    -> 1 when the parameter set is legal
package vcb_mod_cled_pkg;

  function automatic int vcb_max(input int mod);
    return mod - 1;
  endfunction

  // WIDTH is capped at 31 because MOD is carried as an int and must reach 2**WIDTH.
  function automatic bit vcb_params_ok(input int width, input int mod, input int rst_val);
    return (width >= 1) && (width <= 31) && (mod >= 2) &&
           (longint'(mod) <= (longint'(1) << width)) &&
           (rst_val >= 0) && (rst_val < mod);
  endfunction

endpackage

// File: rtl/vcb_mod_cled_next.sv
// rtl/vcb_mod_cled_next.sv - next-state and terminal-count logic of the modulo counter
// Purpose : combinational step of a modulo-MOD counter in either direction.
// Ports   : i_q      in  WIDTH  current counter value
//           i_up     in  1      direction, 1 = increment
//           o_next_q out WIDTH  value after one count step
//           o_tc     out 1      terminal count for the current direction
// Config  : VCB_MOD_CLED_SAT_EN makes the step hold at the bounds instead of wrapping.
module vcb_mod_next
  import vcb_mod_cled_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_next_q,
  output logic             o_tc
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(vcb_max(MOD));

`ifdef VCB_MOD_CLED_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [WIDTH:0] w_inc_ext;
  logic           w_at_max;
  logic           w_at_zero;

  // The increment is formed one bit wider so that reaching MOD is detectable
  // even when MOD == 2**WIDTH; in that case the truncated sum is a plain wrap.
  assign w_inc_ext = {1'b0, i_q} + (WIDTH+1)'(1);
  assign w_at_max  = (w_inc_ext == MOD_EXT);
  assign w_at_zero = (i_q == '0);

  always_comb begin
    o_next_q = i_q;
    if (i_up) begin
      o_next_q = w_at_max ? (SAT ? i_q : '0) : w_inc_ext[WIDTH-1:0];
    end else begin
      o_next_q = w_at_zero ? (SAT ? i_q : MAX_Q) : (i_q - WIDTH'(1));
    end
  end

  assign o_tc = i_up ? w_at_max : w_at_zero;

endmodule

// File: rtl/vcb_mod_cled.sv
// rtl/vcb_mod_cled.sv - WIDTH-bit modulo-MOD up/down counter with load, tc and cascade enable
// Purpose : loadable bidirectional modulo counter for dividers, timers and digit chains.
// Ports   : clk  in  1      rising-edge clock
//           clr  in  1      synchronous clear, active-high, highest priority
//           ce   in  1      count enable
//           up   in  1      direction, 1 = increment
//           l    in  1      synchronous load strobe (beats ce)
//           di   in  WIDTH  load data, clamped to MOD-1 when out of range
//           q    out WIDTH  counter value
//           tc   out 1      terminal count for the current direction
//           ceo  out 1      ce & tc, drives the next stage's ce
//           lerr out 1      one-cycle flag after an out-of-range load
// Config  : VCB_MOD_CLED_SAT_EN selects saturating instead of wrapping counting.
module vcb_mod_cled
  import vcb_mod_cled_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MOD     = 16,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic             up,
  input  logic             l,
  input  logic [WIDTH-1:0] di,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ceo,
  output logic             lerr
);

  if (!vcb_params_ok(WIDTH, MOD, RST_VAL)) begin : g_param_check
    $error("vcb_mod_cled: illegal parameters WIDTH=%0d MOD=%0d RST_VAL=%0d",
           WIDTH, MOD, RST_VAL);
  end

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(vcb_max(MOD));
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_q;
  logic             r_lerr;
  logic [WIDTH-1:0] w_next_q;
  logic             w_tc;
  logic             w_load_oor;

  vcb_mod_next #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_next (
    .i_q      (r_q),
    .i_up     (up),
    .o_next_q (w_next_q),
    .o_tc     (w_tc)
  );

  // Never true when MOD == 2**WIDTH, since di cannot exceed 2**WIDTH-1.
  assign w_load_oor = ({1'b0, di} >= MOD_EXT);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q    <= RST_Q;
      r_lerr <= 1'b0;
    end else begin
      r_lerr <= 1'b0;
      if (l) begin
        if (w_load_oor) begin
          r_q    <= MAX_Q;
          r_lerr <= 1'b1;
        end else begin
          r_q <= di;
        end
      end else if (ce) begin
        r_q <= w_next_q;
      end
    end
  end

  assign q    = r_q;
  assign lerr = r_lerr;
  assign tc   = w_tc;
  assign ceo  = ce & w_tc;

endmodule

// File: tb/tb_vcb_mod_cled.sv
// tb/tb_vcb_mod_cled.sv - self-checking bench for vcb_mod_cled (WIDTH=4, MOD=10)
module tb_vcb_mod_cled;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       ce  = 1'b0;
  logic       up  = 1'b1;
  logic       l   = 1'b0;
  logic [3:0] di  = 4'd0;
  logic [3:0] q;
  logic       tc, ceo, lerr;
  logic [3:0] hi_q;
  logic       hi_tc, hi_ceo, hi_lerr;

  int n_cmp = 0;
  int n_err = 0;
  int m_q   = 0;
  bit m_lerr = 1'b0;

`ifdef VCB_MOD_CLED_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  vcb_mod_cled #(.WIDTH(4), .MOD(10), .RST_VAL(0)) dut (
    .clk(clk), .clr(clr), .ce(ce), .up(up), .l(l), .di(di),
    .q(q), .tc(tc), .ceo(ceo), .lerr(lerr)
  );

  // Upper digit of a two-stage decimal chain; its enable is the lower stage's ceo.
  vcb_mod_cled #(.WIDTH(4), .MOD(10), .RST_VAL(0)) hi (
    .clk(clk), .clr(clr), .ce(ceo), .up(up), .l(1'b0), .di(4'd0),
    .q(hi_q), .tc(hi_tc), .ceo(hi_ceo), .lerr(hi_lerr)
  );

  // Reference: counter as an integer in 0..9, wrapping with modulo arithmetic.
  task automatic drive(input bit c, input bit lv, input bit cev, input bit upv, input logic [3:0] d);
    clr = c; l = lv; ce = cev; up = upv; di = d;
    @(posedge clk);
    m_lerr = 1'b0;
    if (c) begin
      m_q = 0;
    end else if (lv) begin
      if (int'(d) >= 10) begin m_q = 9; m_lerr = 1'b1; end
      else m_q = int'(d);
    end else if (cev) begin
      if (upv) m_q = (SAT && m_q == 9) ? 9 : (m_q + 1) % 10;
      else     m_q = (SAT && m_q == 0) ? 0 : (m_q + 9) % 10;
    end
    #1;
  endtask

  function automatic bit exp_tc();
    return up ? (m_q == 9) : (m_q == 0);
  endfunction

  task automatic test_reset();
    drive(1, 0, 0, 1, 4'd0);
    n_cmp++; if (q !== 4'd0) begin n_err++; $display("FAIL reset_q: got %0d want 0", q); end
    n_cmp++; if (lerr !== 1'b0) begin n_err++; $display("FAIL reset_lerr: got %0b want 0", lerr); end
    n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL reset_tc: got %0b want 0", tc); end
  endtask

  task automatic test_clr_mid();
    drive(0, 1, 0, 1, 4'd7);
    n_cmp++; if (q !== 4'd7) begin n_err++; $display("FAIL clr_mid_pre: got %0d want 7", q); end
    drive(1, 0, 1, 1, 4'd0);
    n_cmp++; if (q !== 4'd0) begin n_err++; $display("FAIL clr_mid_q: got %0d want 0", q); end
    n_cmp++; if (lerr !== 1'b0) begin n_err++; $display("FAIL clr_mid_lerr: got %0b want 0", lerr); end
  endtask

  task automatic test_count_up();
    int got_p = 0;
    int exp_p = 0;
    drive(1, 0, 0, 1, 4'd0);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 1, 4'd0);
      n_cmp++; if (q !== 4'(m_q)) begin n_err++; $display("FAIL up_q[%0d]: got %0d want %0d", i, q, m_q); end
      n_cmp++; if (tc !== exp_tc()) begin n_err++; $display("FAIL up_tc[%0d]: got %0b want %0b", i, tc, exp_tc()); end
      if (ceo === 1'b1) got_p++;
      if (exp_tc()) exp_p++;
    end
    n_cmp++; if (got_p != exp_p) begin n_err++; $display("FAIL up_ceo_pulses: got %0d want %0d", got_p, exp_p); end
  endtask

  task automatic test_count_down();
    drive(0, 1, 0, 0, 4'd2);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 4'd0);
      n_cmp++; if (q !== 4'(m_q)) begin n_err++; $display("FAIL down_q[%0d]: got %0d want %0d", i, q, m_q); end
      n_cmp++; if (tc !== exp_tc()) begin n_err++; $display("FAIL down_tc[%0d]: got %0b want %0b", i, tc, exp_tc()); end
    end
  endtask

  task automatic test_load();
    drive(0, 1, 0, 1, 4'd6);
    drive(0, 1, 0, 1, 4'b0100);
    n_cmp++; if (q !== 4'd4) begin n_err++; $display("FAIL load_q: got %0d want 4", q); end
    n_cmp++; if (lerr !== 1'b0) begin n_err++; $display("FAIL load_lerr: got %0b want 0", lerr); end
    drive(0, 1, 1, 1, 4'd13);
    n_cmp++; if (q !== 4'd9) begin n_err++; $display("FAIL load_oor_q: got %0d want 9", q); end
    n_cmp++; if (lerr !== 1'b1) begin n_err++; $display("FAIL load_oor_lerr: got %0b want 1", lerr); end
    drive(0, 0, 0, 1, 4'd0);
    n_cmp++; if (lerr !== 1'b0) begin n_err++; $display("FAIL load_oor_lerr_drop: got %0b want 0", lerr); end
    n_cmp++; if (q !== 4'd9) begin n_err++; $display("FAIL hold_q: got %0d want 9", q); end
    // Stalled at the bound: tc still asserted, ceo gated by ce.
    n_cmp++; if (tc !== 1'b1) begin n_err++; $display("FAIL stall_tc: got %0b want 1", tc); end
    n_cmp++; if (ceo !== 1'b0) begin n_err++; $display("FAIL stall_ceo: got %0b want 0", ceo); end
  endtask

  task automatic test_load_clr();
    drive(0, 1, 0, 1, 4'd3);
    drive(1, 1, 1, 1, 4'd5);
    n_cmp++; if (q !== 4'd0) begin n_err++; $display("FAIL load_clr_q: got %0d want 0", q); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0, 1'($urandom),
            1'($urandom), 4'($urandom_range(0, 15)));
      n_cmp++; if (q !== 4'(m_q)) begin n_err++; $display("FAIL rnd_q[%0d]: got %0d want %0d", i, q, m_q); end
      n_cmp++; if (lerr !== m_lerr) begin n_err++; $display("FAIL rnd_lerr[%0d]: got %0b want %0b", i, lerr, m_lerr); end
      n_cmp++; if (tc !== exp_tc()) begin n_err++; $display("FAIL rnd_tc[%0d]: got %0b want %0b", i, tc, exp_tc()); end
      n_cmp++; if (ceo !== (ce & exp_tc())) begin n_err++; $display("FAIL rnd_ceo[%0d]: got %0b want %0b", i, ceo, ce & exp_tc()); end
    end
  endtask

`ifndef VCB_MOD_CLED_SAT_EN
  task automatic test_cascade();
    int cnt = 0;
    drive(1, 0, 0, 1, 4'd0);
    n_cmp++; if ({hi_q, q} !== 8'h00) begin n_err++; $display("FAIL cascade_clr: got %0d%0d want 00", hi_q, q); end
    for (int i = 0; i < 105; i++) begin
      drive(0, 0, 1, 1, 4'd0);
      cnt = (cnt + 1) % 100;
      n_cmp++;
      if (int'(hi_q) * 10 + int'(q) != cnt || hi_q > 4'd9) begin
        n_err++; $display("FAIL cascade[%0d]: got %0d%0d want %0d", i, hi_q, q, cnt);
      end
    end
  endtask
`else
  task automatic test_saturate();
    drive(0, 1, 0, 1, 4'd9);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 4'd0);
      n_cmp++; if (q !== 4'd9) begin n_err++; $display("FAIL sat_up_q[%0d]: got %0d want 9", i, q); end
      n_cmp++; if (ceo !== 1'b1) begin n_err++; $display("FAIL sat_up_ceo[%0d]: got %0b want 1", i, ceo); end
    end
    drive(0, 1, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 4'd0);
      n_cmp++; if (q !== 4'd0) begin n_err++; $display("FAIL sat_dn_q[%0d]: got %0d want 0", i, q); end
      n_cmp++; if (ceo !== 1'b1) begin n_err++; $display("FAIL sat_dn_ceo[%0d]: got %0b want 1", i, ceo); end
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clr_mid();
    test_count_up();
    test_count_down();
    test_load();
    test_load_clr();
`ifndef VCB_MOD_CLED_SAT_EN
    test_cascade();
`else
    test_saturate();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
